// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// A start in IDLE latches the operands and runs a fixed-latency busy period.
// HI/LO are written when the countdown expires. mthi/mtlo writes and
// mfhi/mflo reads are serviced directly.
//
// Handshake: start/weMD act only in a cycle where kill=0 and the unit is IDLE.
// busy rises in that same cycle, combinationally, and stays high until the
// commit edge. Commands that arrive while busy=1 are dropped, not queued.
// The hazard unit must therefore hold md-class instructions while busy=1.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mord,
    input  logic        signmd,
    input  logic        weMD,
    input  logic        wHiLo,
    input  logic        rHiLo,
    input  logic        kill,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        state_dbg
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [31:0] op_a, op_b;
    logic [1:0]  op_mord;
    logic        op_sign;

    logic [31:0] hi_q, lo_q;

    logic        start_eff, we_eff, commit;
    logic        op_is_div;

    // Multiply datapath signals.
    logic [63:0] a_ext, b_ext, product;

    // Divide datapath signals, computed on operand magnitudes.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign start_eff = start & ~kill & (state == IDLE);
    assign we_eff    = weMD & ~kill & (state == IDLE) & ~start;
    assign busy      = start_eff | (state == BUSY);
    assign commit    = (state == BUSY) && (cnt == '0);
    assign op_is_div = (op_mord == 2'b01);

    assign rd_data   = rHiLo ? lo_q : hi_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state;

    // Operand extension and 64-bit product. The low 64 bits of the product
    // are correct for both signed and unsigned extension.
    always_comb begin
        a_ext   = op_sign ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        b_ext   = op_sign ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = a_ext * b_ext;
    end

    // Sign-magnitude divide: the quotient truncates toward zero and the
    // remainder follows the dividend's sign. A zero divisor is replaced by 1
    // so that no X is produced; that result is never committed.
    always_comb begin
        a_neg  = op_sign & op_a[31];
        b_neg  = op_sign & op_b[31];
        a_mag  = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag  = b_neg ? (~op_b + 32'd1) : op_b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // FSM state and countdown register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic: load the countdown on an accepted start, then count down to commit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start_eff) begin
                    state_n = BUSY;
                    cnt_n   = (mord == 2'b01) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, captured when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            op_mord <= '0;
            op_sign <= 1'b0;
        end else if (start_eff) begin
            op_a    <= rs_data;
            op_b    <= rt_data;
            op_mord <= mord;
            op_sign <= signmd;
        end
    end

    // HI/LO update. A commit writes the result, except for a divide by zero,
    // which leaves HI/LO untouched. Direct writes are only possible in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (op_is_div) begin
                if (op_b != 32'd0) begin
                    hi_q <= rem;
                    lo_q <= quot;
                end
            end else begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
            end
        end else if (we_eff) begin
            if (wHiLo) lo_q <= rs_data;
            else       hi_q <= rs_data;
        end
    end

endmodule
